// File: rtl/regfile_wb_sched_if.sv
// Bundle between the execute stage, the load unit, the issue stage and the
// register-file write port. The scheduler takes the slave side.
interface regfile_wb_sched_if #(
  parameter int LD_DEPTH = 2
);
  localparam int CW = $clog2(LD_DEPTH) + 1;

  logic          ex_valid;
  logic [4:0]    ex_rd;
  logic [31:0]   ex_data;
  logic          ld_issue;
  logic [4:0]    ld_issue_rd;
  logic          ld_valid;
  logic          ld_ready;
  logic [4:0]    ld_rd;
  logic [31:0]   ld_data;
  logic          wr;
  logic [4:0]    rd;
  logic [31:0]   rd_d;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic          rs1_busy;
  logic          rs2_busy;
  logic [CW-1:0] ld_count;
  logic          waw_err;

  modport master (
    output ex_valid, ex_rd, ex_data, ld_issue, ld_issue_rd,
           ld_valid, ld_rd, ld_data, rs1, rs2,
    input  ld_ready, wr, rd, rd_d, rs1_busy, rs2_busy, ld_count, waw_err
  );

  modport slave (
    input  ex_valid, ex_rd, ex_data, ld_issue, ld_issue_rd,
           ld_valid, ld_rd, ld_data, rs1, rs2,
    output ld_ready, wr, rd, rd_d, rs1_busy, rs2_busy, ld_count, waw_err
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: shares the single regfile write port between execute
// results (highest priority) and buffered load returns, and tracks registers
// with loads in flight so decode can stall on stale sources.
module regfile_wb_sched #(
  parameter int LD_DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  regfile_wb_sched_if.slave bus
);
  localparam int PW = $clog2(LD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LD_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);

  logic [4:0]    fifo_rd_r   [LD_DEPTH];
  logic [31:0]   fifo_data_r [LD_DEPTH];
  logic [PW-1:0] head_r, head_nxt_s;
  logic [PW-1:0] tail_r, tail_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic          wr_r, wr_nxt_s;
  logic [4:0]    rd_r, rd_nxt_s;
  logic [31:0]   rd_d_r, rd_d_nxt_s;
  logic          from_ld_r, from_ld_nxt_s;
  logic [31:0]   busy_r, busy_nxt_s;
  logic          waw_err_r, waw_err_nxt_s;
  logic          ld_ready_s;
  logic          push_s;
  logic          pop_s;

  // Load handshake: ready depends only on occupancy, a pop needs an idle execute slot.
  always_comb begin
    ld_ready_s = (count_r != FULL_CNT);
    push_s     = bus.ld_valid & ld_ready_s;
    pop_s      = ~bus.ex_valid & (count_r != CNT_ZERO);
  end

  // Next-state: port arbitration, FIFO pointers, scoreboard and sticky WAW flag.
  always_comb begin
    head_nxt_s    = head_r;
    tail_nxt_s    = tail_r;
    count_nxt_s   = count_r;
    wr_nxt_s      = 1'b0;
    rd_nxt_s      = rd_r;
    rd_d_nxt_s    = rd_d_r;
    from_ld_nxt_s = 1'b0;
    busy_nxt_s    = busy_r;
    waw_err_nxt_s = waw_err_r;

    // Execute always wins; register 0 consumes the slot without writing.
    if (bus.ex_valid) begin
      wr_nxt_s   = (bus.ex_rd != 5'd0);
      rd_nxt_s   = bus.ex_rd;
      rd_d_nxt_s = bus.ex_data;
    end else if (pop_s) begin
      wr_nxt_s      = (fifo_rd_r[head_r] != 5'd0);
      rd_nxt_s      = fifo_rd_r[head_r];
      rd_d_nxt_s    = fifo_data_r[head_r];
      from_ld_nxt_s = (fifo_rd_r[head_r] != 5'd0);
      head_nxt_s    = head_r + PTR_ONE;
    end else begin
      wr_nxt_s = 1'b0;
    end

    if (push_s) begin
      tail_nxt_s = tail_r + PTR_ONE;
    end else begin
      tail_nxt_s = tail_r;
    end

    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase

    // The write now on the port commits at this edge; a load commit frees its register.
    if (wr_r & from_ld_r) begin
      busy_nxt_s[rd_r] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end

    // Applied after the clear so a same-edge re-issue keeps the register busy.
    if (bus.ld_issue & (bus.ld_issue_rd != 5'd0)) begin
      busy_nxt_s[bus.ld_issue_rd] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;

    if (bus.ex_valid & (bus.ex_rd != 5'd0) & busy_r[bus.ex_rd]) begin
      waw_err_nxt_s = 1'b1;
    end else begin
      waw_err_nxt_s = waw_err_r;
    end
  end

  // Control and output registers; reset drops any pending write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r    <= PTR_ZERO;
      tail_r    <= PTR_ZERO;
      count_r   <= CNT_ZERO;
      wr_r      <= 1'b0;
      rd_r      <= 5'd0;
      rd_d_r    <= 32'd0;
      from_ld_r <= 1'b0;
      busy_r    <= 32'd0;
      waw_err_r <= 1'b0;
    end else begin
      head_r    <= head_nxt_s;
      tail_r    <= tail_nxt_s;
      count_r   <= count_nxt_s;
      wr_r      <= wr_nxt_s;
      rd_r      <= rd_nxt_s;
      rd_d_r    <= rd_d_nxt_s;
      from_ld_r <= from_ld_nxt_s;
      busy_r    <= busy_nxt_s;
      waw_err_r <= waw_err_nxt_s;
    end
  end

  // Load-result storage, written at the tail on an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LD_DEPTH; i++) begin
        fifo_rd_r[i]   <= 5'd0;
        fifo_data_r[i] <= 32'd0;
      end
    end else if (push_s) begin
      fifo_rd_r[tail_r]   <= bus.ld_rd;
      fifo_data_r[tail_r] <= bus.ld_data;
    end
  end

  assign bus.ld_ready = ld_ready_s;
  assign bus.ld_count = count_r;
  assign bus.wr       = wr_r;
  assign bus.rd       = rd_r;
  assign bus.rd_d     = rd_d_r;
  assign bus.waw_err  = waw_err_r;
  // Bit 0 of the scoreboard is never set, so register 0 always reads not-busy.
  assign bus.rs1_busy = busy_r[bus.rs1];
  assign bus.rs2_busy = busy_r[bus.rs2];
endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler for the 32x32 register file. It shares the file's single write port between the execute stage and the load unit. It buffers load results in a small FIFO and keeps a scoreboard of registers with loads in flight, so the issue stage can stall reads of stale data. It sits between execute/load-return and the regfile's `wr`/`rd`/`rd_d` port.

## Interface
- `LD_DEPTH`, 2: load-result FIFO depth; a power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `ex_valid`  in  1  execute result present this cycle; always accepted, no ready.
- `ex_rd`  in  5  execute destination register.
- `ex_data`  in  32  execute result.
- `ld_issue`  in  1  load issued this cycle; marks `ld_issue_rd` busy.
- `ld_issue_rd`  in  5  destination register of the issued load.
- `ld_valid`  in  1  load data offered.
- `ld_ready`  out  1  FIFO can accept load data.
- `ld_rd`  in  5  load destination register.
- `ld_data`  in  32  load data.
- `wr`  out  1  regfile write enable; registered.
- `rd`  out  5  regfile write address; registered.
- `rd_d`  out  32  regfile write data; registered.
- `rs1`, `rs2`  in  5 each  source registers being decoded.
- `rs1_busy`, `rs2_busy`  out  1 each  source has a load in flight; combinational from the scoreboard.
- `ld_count`  out  $clog2(LD_DEPTH)+1  FIFO occupancy.
- `waw_err`  out  1  sticky; execute wrote a busy register.

## Operation
- **Reset values:** `wr`=0, `rd`=0, `rd_d`=0; FIFO empty, so `ld_count`=0 and `ld_ready`=1; all busy bits 0; `waw_err`=0.
- **Reset mid-operation:** FIFO contents and scoreboard are discarded. No write is issued after `rst_n` falls.
- **Load accept:** a load beat is accepted on an edge where `ld_valid & ld_ready`. It is pushed to the FIFO tail.
- **`ld_ready`:** equals `ld_count != LD_DEPTH`. It does not depend on a pop in the same cycle, so there is no combinational path from `ex_valid`.
- **Write-port arbitration, fixed priority, evaluated each cycle:**
  - If `ex_valid`: register {`ex_rd`, `ex_data`} to the outputs. No pop.
  - Else if the FIFO is non-empty: pop the head and register it to the outputs.
  - Else: `wr`=0 next cycle.
- **Simultaneous push and pop:** allowed. `ld_count` is unchanged.
- **Full FIFO plus `ld_valid`:** the load unit holds `ld_valid`/`ld_rd`/`ld_data` stable until accepted.
- **Load starvation:** a continuous stream of `ex_valid` may starve loads. Once the FIFO is full, backpressure stops the load unit; no data is lost.
- **Register 0:** a selected entry with destination 0 drives `wr`=0, but a FIFO entry is still popped. `ld_issue` with rd=0 sets no busy bit. `rs*_busy` for register 0 is always 0.
- **Scoreboard:** busy[31:1].
  - Set on an edge with `ld_issue`.
  - Cleared on the edge that ends a cycle where `wr`=1 from a FIFO pop to that register; this is the regfile commit edge.
  - Set and clear of the same register on the same edge: set wins.
- **Load counting:** one outstanding load per register. A second `ld_issue` to a busy register is legal but not counted; the first return clears the bit.
- **`waw_err`:** set on an edge where `ex_valid` and busy[`ex_rd`] are both true and `ex_rd` != 0. It clears only on reset.

## Timing
- **Execute path:** `ex_valid` in cycle N gives `wr`=1 in cycle N+1. The regfile commits at the end of N+1.
- **Load path, minimum latency:** accepted at the edge ending cycle N, popped in cycle N+1 if `ex_valid`=0, `wr`=1 in cycle N+2.
- **Busy visibility:** `rs*_busy` reflects busy bits after the current edge. A source whose load commits at the end of cycle K reads busy=0 in cycle K+1. The regfile's registered read launched in K+1 returns the new value.
- **Throughput:** one write per cycle, total.

## Test plan
- **Execute write:** `ex_valid`, `ex_rd`=5, `ex_data`=0xDEADBEEF in cycle 0 -> cycle 1 has `wr`=1, `rd`=5, `rd_d`=0xDEADBEEF; cycle 2 has `wr`=0.
- **Load with scoreboard:** `ld_issue` rd=7 in cycle 0 -> `rs1_busy`=1 with `rs1`=7 from cycle 1. Return `ld_valid` rd=7, data 0x1234 in cycle 3 -> `wr`=1, `rd`=7 in cycle 5; `rs1_busy`=0 in cycle 6.
- **Contention and backpressure:** `ex_valid` held for 6 cycles while 3 load beats are offered (rd 1, 2, 3) ->
  - The first two are accepted and `ld_ready`=0 after the second.
  - Execute writes win every cycle.
  - After `ex_valid` drops, loads write rd 1, 2, 3 in order on consecutive cycles.
- **Register 0 and WAW:**
  - Load to rd=0 -> popped, never `wr`=1.
  - `ld_issue` rd=9, then `ex_valid` rd=9 before the return -> `waw_err`=1 and it stays 1.
- **Set/clear collision:** `ld_issue` rd=4 on the same edge as a FIFO commit to rd=4 -> busy[4] stays 1.
- **Reset mid-operation:** FIFO holding 2 entries, busy[3] set; pulse `rst_n` low asynchronously mid-cycle -> immediately `wr`=0, `ld_count`=0, `ld_ready`=1, all busy 0. No later write of the flushed entries.
